// File: rtl/hdlc_rx_stream_monitor.sv
// Multi-channel HDLC receive bitstream monitor: flag hunting, zero destuffing,
// frame length classification, idle detection and saturating event counters.
module hdlc_rx_stream_monitor #(
  parameter int CHANNELS       = 1,
  parameter int IDLE_LEN       = 8,
  parameter int MIN_FRAME_BITS = 32,
  parameter int MAX_FRAME_BITS = 1024,
  parameter int CNT_W          = 16,
  parameter int LEN_W          = $clog2(MAX_FRAME_BITS + 8)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [CHANNELS-1:0]       Rx,
  input  logic [CHANNELS-1:0]       BitEn,
  input  logic                      Clear,
  output logic [CHANNELS-1:0]       FlagDetect,
  output logic [CHANNELS-1:0]       AbortDetect,
  output logic [CHANNELS-1:0]       FrameEnd,
  output logic [CHANNELS-1:0]       FrameErr,
  output logic [CHANNELS*LEN_W-1:0] FrameBits,
  output logic [CHANNELS-1:0]       FrameActive,
  output logic [CHANNELS-1:0]       Idle,
  output logic [CHANNELS*CNT_W-1:0] FrameCnt,
  output logic [CHANNELS*CNT_W-1:0] ErrCnt,
  output logic [CHANNELS*CNT_W-1:0] AbortCnt
);

  localparam int ONES_MAX = (IDLE_LEN > 7) ? IDLE_LEN : 7;
  localparam int ONES_W   = $clog2(ONES_MAX + 1);

  localparam logic [ONES_W-1:0] ONES_SAT  = ONES_W'(ONES_MAX);
  localparam logic [ONES_W-1:0] ONES_IDLE = ONES_W'(IDLE_LEN);
  localparam logic [ONES_W-1:0] ONES_5    = ONES_W'(5);
  localparam logic [ONES_W-1:0] ONES_6    = ONES_W'(6);
  localparam logic [LEN_W-1:0]  LEN_7     = LEN_W'(7);
  localparam logic [LEN_W-1:0]  LEN_MIN   = LEN_W'(MIN_FRAME_BITS);
  localparam logic [LEN_W-1:0]  LEN_OVF   = LEN_W'(MAX_FRAME_BITS + 7);

  typedef enum logic {
    HUNT = 1'b0,
    OPEN = 1'b1
  } state_e;

  // Clear has priority over a simultaneous increment; counts stick at all-ones.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                            input logic inc,
                                            input logic clr);
    logic [CNT_W-1:0] r;
    r = v;
    if (clr) begin
      r = '0;
    end else if (inc && (v != '1)) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e            state_q, state_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  bits_q, bits_d;
    logic [LEN_W-1:0]  cnt_inc, len_w;
    logic              flag_q, flag_d;
    logic              abort_q, abort_d;
    logic              end_q, end_d;
    logic              err_q, err_d;
    logic              idle_q, idle_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic [CNT_W-1:0]  acnt_q, acnt_d;
    logic              inc_f, inc_e, inc_a;
    logic              rx, en, stuffed;

    assign rx      = Rx[c];
    assign en      = BitEn[c];
    assign cnt_inc = cnt_q + 1'b1;
    // cnt includes the 7 bits of the closing flag ahead of its final zero.
    assign len_w   = (cnt_q > LEN_7) ? (cnt_q - LEN_7) : '0;
    assign stuffed = !rx && (ones_q == ONES_5);

    always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      cnt_d   = cnt_q;
      bits_d  = bits_q;
      flag_d  = 1'b0;
      abort_d = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;
      idle_d  = idle_q;
      inc_f   = 1'b0;
      inc_e   = 1'b0;
      inc_a   = 1'b0;
      if (en) begin
        if (rx) begin
          ones_d = (ones_q == ONES_SAT) ? ones_q : ones_q + 1'b1;
        end else begin
          ones_d = '0;
        end
        flag_d = !rx && (ones_q == ONES_6);
        if (!rx) begin
          idle_d = 1'b0;
        end else if (ones_d >= ONES_IDLE) begin
          idle_d = 1'b1;
        end
        case (state_q)
          HUNT: begin
            if (flag_d) begin
              state_d = OPEN;
              cnt_d   = '0;
            end
          end
          OPEN: begin
            if (flag_d) begin
              cnt_d = '0;
              if (len_w != '0) begin
                end_d  = 1'b1;
                bits_d = len_w;
                if ((len_w < LEN_MIN) || (len_w[2:0] != 3'b000)) begin
                  err_d = 1'b1;
                  inc_e = 1'b1;
                end else begin
                  inc_f = 1'b1;
                end
              end
            end else if (!stuffed) begin
              cnt_d = cnt_inc;
              if (rx && (ones_q == ONES_6)) begin
                // Seventh one: abort only if real frame content preceded it.
                if (cnt_inc > LEN_7) begin
                  abort_d = 1'b1;
                  inc_a   = 1'b1;
                end
                state_d = HUNT;
              end else if (cnt_inc > LEN_OVF) begin
                err_d   = 1'b1;
                inc_e   = 1'b1;
                state_d = HUNT;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
      fcnt_d = bump(fcnt_q, inc_f, Clear);
      ecnt_d = bump(ecnt_q, inc_e, Clear);
      acnt_d = bump(acnt_q, inc_a, Clear);
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        state_q <= HUNT;
        ones_q  <= '0;
        cnt_q   <= '0;
        bits_q  <= '0;
        flag_q  <= 1'b0;
        abort_q <= 1'b0;
        end_q   <= 1'b0;
        err_q   <= 1'b0;
        idle_q  <= 1'b0;
        fcnt_q  <= '0;
        ecnt_q  <= '0;
        acnt_q  <= '0;
      end else begin
        state_q <= state_d;
        ones_q  <= ones_d;
        cnt_q   <= cnt_d;
        bits_q  <= bits_d;
        flag_q  <= flag_d;
        abort_q <= abort_d;
        end_q   <= end_d;
        err_q   <= err_d;
        idle_q  <= idle_d;
        fcnt_q  <= fcnt_d;
        ecnt_q  <= ecnt_d;
        acnt_q  <= acnt_d;
      end
    end

    assign FlagDetect[c]                 = flag_q;
    assign AbortDetect[c]                = abort_q;
    assign FrameEnd[c]                   = end_q;
    assign FrameErr[c]                   = err_q;
    assign FrameActive[c]                = (state_q == OPEN);
    assign Idle[c]                       = idle_q;
    assign FrameBits[c*LEN_W +: LEN_W]   = bits_q;
    assign FrameCnt[c*CNT_W +: CNT_W]    = fcnt_q;
    assign ErrCnt[c*CNT_W +: CNT_W]      = ecnt_q;
    assign AbortCnt[c*CNT_W +: CNT_W]    = acnt_q;
  end

endmodule

// File: doc/hdlc_rx_stream_monitor.md
Name: hdlc_rx_stream_monitor

Overview:
- Multi-channel, parametrised RTL monitor of raw HDLC serial bitstreams.
- Per channel it hunts for flags, removes stuffed zeros, measures the destuffed frame length, and classifies each closure as good, error, abort or overflow.
- It also flags idle line and keeps saturating event counters.
- Sits beside the Rx path as a synthesizable, reusable successor to the bench-only flag/abort/idle checks; outputs feed scoreboards and status logic.

Parameters:
CHANNELS, 1, number of independent serial channels
IDLE_LEN, 8, consecutive ones that declare idle (must be >= 8)
MIN_FRAME_BITS, 32, minimum legal destuffed frame length (includes FCS)
MAX_FRAME_BITS, 1024, maximum legal destuffed length; multiple of 8
CNT_W, 16, event counter width
LEN_W, $clog2(MAX_FRAME_BITS+8), derived; frame length field width

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous, active-high reset
Rx  in  CHANNELS  serial bit per channel
BitEn  in  CHANNELS  Rx[c] sampled only when BitEn[c]=1
Clear  in  1  synchronous clear of all counters
FlagDetect  out  CHANNELS  1-cycle pulse per flag
AbortDetect  out  CHANNELS  1-cycle pulse per abort of a started frame
FrameEnd  out  CHANNELS  1-cycle pulse when a non-empty frame closes
FrameErr  out  CHANNELS  1-cycle pulse: bad length, misalignment or overflow
FrameBits  out  CHANNELS*LEN_W  destuffed length; valid with FrameEnd, held until next FrameEnd
FrameActive  out  CHANNELS  level, channel in OPEN state
Idle  out  CHANNELS  level, line idle
FrameCnt  out  CHANNELS*CNT_W  good frames
ErrCnt  out  CHANNELS*CNT_W  FrameErr events
AbortCnt  out  CHANNELS*CNT_W  AbortDetect events

Behaviour:
- Reset values: all outputs 0, state HUNT, ones/bit counters 0; takes effect immediately on Rst, including mid-frame.
- Channels are fully independent. Nothing advances on cycles with BitEn[c]=0.
- Every output is registered. Pulses assert in the cycle after the BitEn cycle that sampled the deciding bit.
- ones[c]: increments on a 1, saturating at max(IDLE_LEN,7); cleared on a 0.
- Flag: a 0 sampled with ones==6. Valid in any state; FlagDetect pulses.
- State machine, 2 states:
  - HUNT:
    - on flag -> OPEN, cnt=0.
    - all other bits ignored.
  - OPEN, on each bit:
    - A 0 with ones==5 is a stuffed zero: dropped, cnt unchanged.
    - A 0 with ones==6 is a flag closure:
      - len = cnt-7, saturating at 0.
      - If len>0: FrameEnd pulse and FrameBits=len.
      - If additionally len<MIN_FRAME_BITS or len%8!=0: FrameErr pulse and ErrCnt++; otherwise FrameCnt++.
      - In all cases stay OPEN with cnt=0. This covers back-to-back and shared-zero flags, which produce no FrameEnd.
    - Any other bit: cnt++.
    - 7th consecutive 1:
      - if cnt (including this bit) > 7: AbortDetect pulse and AbortCnt++.
      - always -> HUNT.
      - Plain idle after a closing flag therefore gives no abort.
    - Overflow, cnt > MAX_FRAME_BITS+7: FrameErr pulse (no FrameEnd), ErrCnt++, -> HUNT.
- Idle: set when ones reaches IDLE_LEN; cleared in the cycle after a 0 is sampled; independent of state.
- Counters:
  - saturate at all-ones.
  - Clear and an increment in the same cycle: Clear wins (counter=0).
- FrameActive=1 exactly while in OPEN.

Test Plan:
1. Rst pulse, then Rx=1 for 10 BitEn cycles on ch0 -> Idle rises the cycle after the 8th one; no FlagDetect/AbortDetect; all counters 0.
2. Flag, bytes 0xFF 0x00 0xAA 0x55 LSB-first with one stuffed 0 after the first five ones, flag -> FlagDetect x2, FrameEnd with FrameBits=32, FrameErr=0, FrameCnt=1.
3. Flag, 12 data bits, then 9 ones -> AbortDetect exactly once (cycle after 7th one), AbortCnt=1, FrameActive falls, no FrameEnd; a new flag restarts OPEN.
4. Flag, 35 data bits, flag -> FrameEnd+FrameErr, FrameBits=35, ErrCnt=1. Repeat with 24 bits -> FrameErr (short).
5. Three back-to-back flags, then a shared-zero flag pair 011111101111110 -> 5 FlagDetect pulses, no FrameEnd, counters unchanged.
6. MAX_FRAME_BITS=64, CHANNELS=2:
   - ch0 gets flag plus 80 zeros -> FrameErr on the 72nd bit, then HUNT.
   - ch1 concurrently runs scenario 2 with random BitEn gaps -> same results as scenario 2.
   - Clear asserted together with ch1's FrameCnt increment -> FrameCnt=0.
   - Rst mid-frame -> all outputs 0 at once.
